// File: rtl/apb_csr_bridge.sv
// APB3 slave front-end that turns APB transfers into one-cycle CSR register-file strobes.
// Optional macro APB_CSR_SLVERR_EN enables address checking with PSLVERR responses.
module apb_csr_bridge #(
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 3,
  parameter int PADDR_W  = 8,
  parameter int NUM_REGS = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_psel,
  input  logic               i_penable,
  input  logic               i_pwrite,
  input  logic [PADDR_W-1:0] i_paddr,
  input  logic [DATA_W-1:0]  i_pwdata,
  output logic [DATA_W-1:0]  o_prdata,
  output logic               o_pready,
  output logic               o_pslverr,
  output logic               o_wr_en,
  output logic               o_rd_en,
  output logic [REG_AW-1:0]  o_wrAddr,
  output logic [DATA_W-1:0]  o_wrData,
  input  logic [DATA_W-1:0]  i_rdData
);

`ifdef APB_CSR_SLVERR_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WR_ACC, S_RD_REQ, S_RD_ACC, S_ERR_ACC
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WR_ACC, S_RD_REQ, S_RD_ACC
  } state_t;
`endif

  localparam bit CfgOk = (PADDR_W >= REG_AW + 2) && (NUM_REGS <= (2 ** REG_AW));

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_prdata;
  logic [DATA_W-1:0]   w_prdata_nxt;
  logic                r_pready;
  logic                w_pready_nxt;
  logic                r_wr_en;
  logic                w_wr_en_nxt;
  logic                r_rd_en;
  logic                w_rd_en_nxt;
  logic [REG_AW-1:0]   r_wrAddr;
  logic [REG_AW-1:0]   w_wrAddr_nxt;
  logic [DATA_W-1:0]   r_wrData;
  logic [DATA_W-1:0]   w_wrData_nxt;
  logic                w_setup;
  logic                w_done;
  logic                w_unused;

  assign w_setup  = i_psel & ~i_penable;
  assign w_done   = i_psel & i_penable & r_pready;
  // Without address checking only the index bits matter; the rest are deliberately ignored.
  assign w_unused = ^{i_paddr, CfgOk};

`ifdef APB_CSR_SLVERR_EN
  logic r_pslverr;
  logic w_pslverr_nxt;
  logic w_illegal;

  function automatic logic addr_illegal(input logic [PADDR_W-1:0] a);
    logic bad;
    bad = (a[1:0] != 2'b00);
    if (int'(a[REG_AW+1:2]) >= NUM_REGS) bad = 1'b1;
    for (int b = REG_AW + 2; b < PADDR_W; b++) begin
      if (a[b]) bad = 1'b1;
    end
    return bad;
  endfunction

  assign w_illegal = addr_illegal(i_paddr);
  assign o_pslverr = r_pslverr;
`else
  assign o_pslverr = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_prdata_nxt = r_prdata;
    w_pready_nxt = r_pready;
    w_wr_en_nxt  = 1'b0;
    w_rd_en_nxt  = 1'b0;
    w_wrAddr_nxt = r_wrAddr;
    w_wrData_nxt = r_wrData;
`ifdef APB_CSR_SLVERR_EN
    w_pslverr_nxt = r_pslverr;
`endif
    case (r_state)
      S_IDLE: begin
        w_pready_nxt = 1'b0;
`ifdef APB_CSR_SLVERR_EN
        w_pslverr_nxt = 1'b0;
`endif
        // PENABLE without a preceding setup phase falls through here and is ignored.
        if (w_setup) begin
          w_wrAddr_nxt = i_paddr[REG_AW+1:2];
          w_wrData_nxt = i_pwdata;
`ifdef APB_CSR_SLVERR_EN
          if (w_illegal) begin
            w_state_nxt   = S_ERR_ACC;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
            w_prdata_nxt  = '0;
          end else
`endif
          if (i_pwrite) begin
            w_state_nxt  = S_WR_ACC;
            w_wr_en_nxt  = 1'b1;
            w_pready_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RD_REQ;
            w_rd_en_nxt = 1'b1;
          end
        end
      end
      S_WR_ACC: begin
        if (!i_psel || w_done) begin
          w_state_nxt  = S_IDLE;
          w_pready_nxt = 1'b0;
        end
      end
      S_RD_REQ: begin
        // Read data is only valid alongside the strobe, so it is captured here, once.
        if (!i_psel) begin
          w_state_nxt  = S_IDLE;
          w_pready_nxt = 1'b0;
        end else begin
          w_state_nxt  = S_RD_ACC;
          w_prdata_nxt = i_rdData;
          w_pready_nxt = 1'b1;
        end
      end
      S_RD_ACC: begin
        if (!i_psel || w_done) begin
          w_state_nxt  = S_IDLE;
          w_pready_nxt = 1'b0;
        end
      end
`ifdef APB_CSR_SLVERR_EN
      S_ERR_ACC: begin
        if (!i_psel || w_done) begin
          w_state_nxt   = S_IDLE;
          w_pready_nxt  = 1'b0;
          w_pslverr_nxt = 1'b0;
        end
      end
`endif
      default: begin
        w_state_nxt  = S_IDLE;
        w_pready_nxt = 1'b0;
`ifdef APB_CSR_SLVERR_EN
        w_pslverr_nxt = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prdata <= '0;
      r_pready <= 1'b0;
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_wrAddr <= '0;
      r_wrData <= '0;
    end else begin
      r_prdata <= w_prdata_nxt;
      r_pready <= w_pready_nxt;
      r_wr_en  <= w_wr_en_nxt;
      r_rd_en  <= w_rd_en_nxt;
      r_wrAddr <= w_wrAddr_nxt;
      r_wrData <= w_wrData_nxt;
    end
  end

`ifdef APB_CSR_SLVERR_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pslverr <= 1'b0;
    end else begin
      r_pslverr <= w_pslverr_nxt;
    end
  end
`endif

  assign o_prdata = r_prdata;
  assign o_pready = r_pready;
  assign o_wr_en  = r_wr_en;
  assign o_rd_en  = r_rd_en;
  assign o_wrAddr = r_wrAddr;
  assign o_wrData = r_wrData;

endmodule

// File: tb/tb_apb_csr_bridge.sv
// Directed self-checking bench for apb_csr_bridge (default parameters).
module tb_apb_csr_bridge;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = '0, pwdata = '0, rddata = '0;
  logic [7:0] prdata, wrdata;
  logic [2:0] wraddr;
  logic       pready, pslverr, wr_en, rd_en;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  int w0, r0;

  apb_csr_bridge #(.DATA_W(8), .REG_AW(3), .PADDR_W(8), .NUM_REGS(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata), .o_pready(pready),
    .o_pslverr(pslverr), .o_wr_en(wr_en), .o_rd_en(rd_en), .o_wrAddr(wraddr),
    .o_wrData(wrdata), .i_rdData(rddata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) wr_cnt++;
    if (rd_en) rd_cnt++;
    if (wr_en && rd_en) both_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setup(input logic wr, input logic [7:0] a, input logic [7:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
  endtask

  task automatic idle_bus();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setup(1'b1, 8'h08, 8'hFF);
    tick(); tick();
    chk("reset_pready", {7'd0, pready}, 8'h00);
    chk("reset_pslverr", {7'd0, pslverr}, 8'h00);
    chk("reset_wr_en", {7'd0, wr_en}, 8'h00);
    chk("reset_rd_en", {7'd0, rd_en}, 8'h00);
    chk("reset_prdata", prdata, 8'h00);
    chk("reset_wrAddr", {5'd0, wraddr}, 8'h00);
    chk("reset_wrData", wrdata, 8'h00);
    idle_bus();
    rst = 1'b0;
    tick();
    chk("post_reset_no_strobe", {6'd0, wr_en, rd_en}, 8'h00);
  endtask

  task automatic test_write();
    w0 = wr_cnt; r0 = rd_cnt;
    setup(1'b1, 8'h08, 8'h64);
    tick();
    chk("wr_en_pulse", {7'd0, wr_en}, 8'h01);
    chk("wr_addr", {5'd0, wraddr}, 8'h02);
    chk("wr_data", wrdata, 8'h64);
    chk("wr_pready", {7'd0, pready}, 8'h01);
    chk("wr_pslverr", {7'd0, pslverr}, 8'h00);
    penable = 1'b1;
    tick();
    chk("wr_en_drop", {7'd0, wr_en}, 8'h00);
    chk("wr_pready_clear", {7'd0, pready}, 8'h00);
    idle_bus();
    tick();
    chk("wr_strobe_count", 8'(wr_cnt - w0), 8'h01);
    chk("wr_no_rd_strobe", 8'(rd_cnt - r0), 8'h00);
  endtask

  task automatic test_read();
    w0 = wr_cnt; r0 = rd_cnt;
    setup(1'b0, 8'h0C, 8'h00);
    rddata = 8'h00;
    tick();
    chk("rd_en_pulse", {7'd0, rd_en}, 8'h01);
    chk("rd_addr", {5'd0, wraddr}, 8'h03);
    chk("rd_wait_pready", {7'd0, pready}, 8'h00);
    penable = 1'b1;
    rddata = 8'h5A;
    tick();
    chk("rd_en_drop", {7'd0, rd_en}, 8'h00);
    chk("rd_pready", {7'd0, pready}, 8'h01);
    chk("rd_prdata", prdata, 8'h5A);
    tick();
    chk("rd_pready_clear", {7'd0, pready}, 8'h00);
    chk("rd_prdata_hold", prdata, 8'h5A);
    idle_bus();
    tick();
    chk("rd_strobe_count", 8'(rd_cnt - r0), 8'h01);
    chk("rd_no_wr_strobe", 8'(wr_cnt - w0), 8'h00);
  endtask

  task automatic test_back_to_back();
    w0 = wr_cnt; r0 = rd_cnt;
    setup(1'b1, 8'h00, 8'h11);
    tick();
    chk("b2b_wr_en", {7'd0, wr_en}, 8'h01);
    chk("b2b_wr_addr", {5'd0, wraddr}, 8'h00);
    penable = 1'b1;
    tick();
    chk("b2b_gap_strobes", {6'd0, wr_en, rd_en}, 8'h00);
    setup(1'b0, 8'h00, 8'h00);
    tick();
    chk("b2b_rd_strobes", {6'd0, wr_en, rd_en}, 8'h01);
    penable = 1'b1;
    rddata = 8'h11;
    tick();
    chk("b2b_rd_pready", {7'd0, pready}, 8'h01);
    chk("b2b_rd_prdata", prdata, 8'h11);
    tick();
    chk("b2b_done_pready", {7'd0, pready}, 8'h00);
    idle_bus();
    tick();
    chk("b2b_wr_count", 8'(wr_cnt - w0), 8'h01);
    chk("b2b_rd_count", 8'(rd_cnt - r0), 8'h01);
  endtask

  task automatic test_illegal_addr();
    w0 = wr_cnt; r0 = rd_cnt;
    setup(1'b0, 8'h20, 8'h00);
    tick();
`ifdef APB_CSR_SLVERR_EN
    chk("err_rd_strobes", {6'd0, wr_en, rd_en}, 8'h00);
    chk("err_rd_pready", {7'd0, pready}, 8'h01);
    chk("err_rd_pslverr", {7'd0, pslverr}, 8'h01);
    chk("err_rd_prdata", prdata, 8'h00);
    penable = 1'b1;
    tick();
    chk("err_rd_done", {6'd0, pready, pslverr}, 8'h00);
`else
    chk("alias_rd_en", {7'd0, rd_en}, 8'h01);
    chk("alias_rd_addr", {5'd0, wraddr}, 8'h00);
    chk("alias_rd_pslverr", {7'd0, pslverr}, 8'h00);
    penable = 1'b1;
    rddata = 8'h33;
    tick();
    chk("alias_rd_prdata", prdata, 8'h33);
    chk("alias_rd_pslverr2", {6'd0, pready, pslverr}, 8'h02);
    tick();
    chk("alias_rd_done", {7'd0, pready}, 8'h00);
`endif
    setup(1'b1, 8'h05, 8'h77);
    tick();
`ifdef APB_CSR_SLVERR_EN
    chk("err_wr_strobes", {6'd0, wr_en, rd_en}, 8'h00);
    chk("err_wr_resp", {6'd0, pready, pslverr}, 8'h03);
    chk("err_wr_prdata", prdata, 8'h00);
    penable = 1'b1;
    tick();
    chk("err_wr_done", {6'd0, pready, pslverr}, 8'h00);
    idle_bus();
    tick();
    chk("err_no_strobes", 8'((wr_cnt - w0) + (rd_cnt - r0)), 8'h00);
`else
    chk("alias_wr_en", {7'd0, wr_en}, 8'h01);
    chk("alias_wr_addr", {5'd0, wraddr}, 8'h01);
    chk("alias_wr_data", wrdata, 8'h77);
    chk("alias_wr_pslverr", {7'd0, pslverr}, 8'h00);
    penable = 1'b1;
    tick();
    chk("alias_wr_done", {7'd0, pready}, 8'h00);
    idle_bus();
    tick();
`endif
  endtask

  task automatic test_reset_mid_read();
    setup(1'b0, 8'h04, 8'h00);
    tick();
    chk("mid_rd_en", {7'd0, rd_en}, 8'h01);
    penable = 1'b1;
    rddata = 8'h99;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rd_en", {7'd0, rd_en}, 8'h00);
    chk("async_rst_pready", {6'd0, pready, pslverr}, 8'h00);
    chk("async_rst_prdata", prdata, 8'h00);
    chk("async_rst_wrAddr", {5'd0, wraddr}, 8'h00);
    chk("async_rst_wrData", wrdata, 8'h00);
    idle_bus();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_release_idle", {5'd0, wr_en, rd_en, pready}, 8'h00);
    setup(1'b1, 8'h04, 8'hA5);
    tick();
    chk("post_rst_wr_en", {7'd0, wr_en}, 8'h01);
    chk("post_rst_wr_addr", {5'd0, wraddr}, 8'h01);
    chk("post_rst_wr_data", wrdata, 8'hA5);
    chk("post_rst_pready", {7'd0, pready}, 8'h01);
    penable = 1'b1;
    tick();
    chk("post_rst_done", {7'd0, pready}, 8'h00);
    idle_bus();
    tick();
  endtask

  task automatic test_abort();
    setup(1'b0, 8'h08, 8'h00);
    tick();
    penable = 1'b1;
    rddata = 8'h3C;
    tick();
    chk("abort_pre_prdata", prdata, 8'h3C);
    tick();
    idle_bus();
    tick();
    setup(1'b0, 8'h0C, 8'h00);
    tick();
    chk("abort_rd_en", {7'd0, rd_en}, 8'h01);
    idle_bus();
    rddata = 8'hEE;
    tick();
    chk("abort_pready", {7'd0, pready}, 8'h00);
    chk("abort_prdata_hold", prdata, 8'h3C);
    chk("abort_rd_en_drop", {7'd0, rd_en}, 8'h00);
    tick();
    chk("abort_stays_idle", {5'd0, wr_en, rd_en, pready}, 8'h00);
    setup(1'b1, 8'h10, 8'h42);
    tick();
    chk("abort_next_wr_en", {7'd0, wr_en}, 8'h01);
    chk("abort_next_wr_addr", {5'd0, wraddr}, 8'h04);
    chk("abort_next_pready", {7'd0, pready}, 8'h01);
    penable = 1'b1;
    tick();
    chk("abort_next_done", {7'd0, pready}, 8'h00);
    idle_bus();
    tick();
  endtask

  task automatic test_penable_in_idle();
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h08; pwdata = 8'h5F;
    tick();
    chk("pen_idle_strobes", {5'd0, wr_en, rd_en, pready}, 8'h00);
    tick();
    chk("pen_idle_strobes2", {5'd0, wr_en, rd_en, pready}, 8'h00);
    chk("pen_idle_wrData", wrdata, 8'h42);
    idle_bus();
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_illegal_addr();
    test_reset_mid_read();
    test_abort();
    test_penable_in_idle();
    chk("never_both_strobes", 8'(both_cnt), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
